// File: rtl/aes_cipher.sv
// AES-128/192/256 block encryptor. One 128-bit plaintext block in, 16 ciphertext
// bytes out (MSB first). The key schedule is cached between blocks.
module aes_cipher (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [1:0]   key_len_i,
  input  logic [255:0] key_i,
  input  logic         key_update_i,
  input  logic         key_len_update_i,
  input  logic [127:0] s_axis_tdata_i,
  input  logic         s_axis_tvalid_i,
  output logic         s_axis_tready_o,
  output logic [7:0]   m_axis_tdata_o,
  output logic         m_axis_tvalid_o,
  output logic         m_axis_tlast_o,
  output logic         m_axis_tkeep_o,
  output logic         m_axis_tstrb_o,
  output logic         m_axis_tid_o,
  output logic         m_axis_tdest_o,
  output logic         m_axis_tuser_o,
  input  logic         m_axis_tready_i
);

  typedef enum logic [2:0] {NOKEY, IDLE, KEYEXP, ROUND, OUTPUT} state_e;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at bit 2047-8x, i.e. {~x, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // SubBytes, ShiftRows, MixColumns (skipped on the last round), AddRoundKey.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c+1];
      a2 = sr[4*c+2];
      a3 = sr[4*c+3];
      if (last) res[127-32*c -: 32] = {a0, a1, a2, a3};
      else res[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                  a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                  a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                  xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return res ^ k;
  endfunction

  function automatic logic [5:0] nk_of(input logic [1:0] l);
    case (l)
      2'b01:   return 6'd6;
      2'b10:   return 6'd8;
      default: return 6'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] l);
    case (l)
      2'b01:   return 4'd12;
      2'b10:   return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  state_e         state_q;
  logic [255:0]   key_sh_q;
  logic [1:0]     klen_sh_q, klen_q;
  logic           pend_q;
  logic [31:0]    rk_q [60];
  logic [5:0]     wi_q;
  logic [2:0]     kc_q;
  logic [7:0]     rcon_q;
  logic [127:0]   st_q, out_q;
  logic [3:0]     rnd_q, bcnt_q;
  logic           tvalid_q, tlast_q;

  logic [5:0]     nk, last_w, rk_base;
  logic [3:0]     nr;
  logic [2:0]     kc_last;
  logic [31:0]    prev_w, temp_w, w_d;
  logic [127:0]   rk_cur, round_d;
  logic           strobe, go_kx;

  // Key-schedule word generator, current round datapath and transition decode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    nk      = nk_of(klen_q);
    nr      = nr_of(klen_q);
    last_w  = {nr, 2'b11};
    kc_last = 3'(nk - 6'd1);
    prev_w  = rk_q[wi_q - 6'd1];
    temp_w  = prev_w;
    if (kc_q == 3'd0) temp_w = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon_q, 24'h0};
    else if (nk == 6'd8 && kc_q == 3'd4) temp_w = sub_word(prev_w);
    w_d     = rk_q[wi_q - nk] ^ temp_w;
    rk_base = {rnd_q, 2'b00};
    rk_cur  = {rk_q[rk_base], rk_q[rk_base + 6'd1], rk_q[rk_base + 6'd2], rk_q[rk_base + 6'd3]};
    round_d = aes_round(st_q, rk_cur, rnd_q == nr);
    strobe  = key_update_i | key_len_update_i;
    go_kx   = pend_q && (state_q == NOKEY || state_q == IDLE ||
              (state_q == OUTPUT && m_axis_tready_i && bcnt_q == 4'd15));
  end

  assign s_axis_tready_o = en_i && state_q == IDLE && !pend_q;
  assign m_axis_tdata_o  = out_q[127:120];
  assign m_axis_tvalid_o = tvalid_q;
  assign m_axis_tlast_o  = tlast_q;
  assign m_axis_tkeep_o  = 1'b1;
  assign m_axis_tstrb_o  = 1'b1;
  assign m_axis_tid_o    = 1'b0;
  assign m_axis_tdest_o  = 1'b0;
  assign m_axis_tuser_o  = 1'b0;

  // Main FSM: key capture, key expansion, rounds and serial output; frozen while en_i is low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
      state_q   <= NOKEY;
      key_sh_q  <= '0;
      klen_sh_q <= '0;
      klen_q    <= '0;
      pend_q    <= 1'b0;
      wi_q      <= '0;
      kc_q      <= '0;
      rcon_q    <= '0;
      st_q      <= '0;
      out_q     <= '0;
      rnd_q     <= '0;
      bcnt_q    <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      // NOTE: the round-key array is reset on purpose so no key material survives a reset.
      for (int i = 0; i < 60; i++) rk_q[i] <= '0;
    end else if (en_i) begin
      if (key_update_i) key_sh_q <= key_i;
      if (key_len_update_i) klen_sh_q <= key_len_i;
      case (state_q)
        IDLE: begin
          if (s_axis_tready_o && s_axis_tvalid_i) begin
            st_q    <= s_axis_tdata_i ^ {rk_q[0], rk_q[1], rk_q[2], rk_q[3]};
            rnd_q   <= 4'd1;
            state_q <= ROUND;
          end
        end
        KEYEXP: begin
          rk_q[wi_q] <= w_d;
          wi_q       <= wi_q + 6'd1;
          kc_q       <= (kc_q == kc_last) ? 3'd0 : kc_q + 3'd1;
          if (kc_q == 3'd0) rcon_q <= xtime(rcon_q);
          if (wi_q == last_w) begin
            pend_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        ROUND: begin
          st_q <= round_d;
          if (rnd_q == nr) begin
            out_q    <= round_d;
            bcnt_q   <= 4'd0;
            tvalid_q <= 1'b1;
            state_q  <= OUTPUT;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        OUTPUT: begin
          if (m_axis_tready_i) begin
            out_q   <= {out_q[119:0], 8'h00};
            bcnt_q  <= bcnt_q + 4'd1;
            tlast_q <= (bcnt_q == 4'd14);
            if (bcnt_q == 4'd15) begin
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              state_q  <= IDLE;
            end
          end
        end
        default: ;
      endcase
      // Start of key expansion: shadow becomes active, first Nk words come straight from the key.
      if (go_kx) begin
        klen_q  <= klen_sh_q;
        for (int i = 0; i < 8; i++) rk_q[i] <= key_sh_q[255-32*i -: 32];
        wi_q    <= nk_of(klen_sh_q);
        kc_q    <= 3'd0;
        rcon_q  <= 8'h01;
        state_q <= KEYEXP;
      end
      if (strobe) pend_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_cipher.sv
// Directed bench for aes_cipher using the FIPS-197 example vectors.
module tb_aes_cipher;

  logic         clk_i = 1'b0;
  logic         rst_i, en_i;
  logic [1:0]   key_len_i;
  logic [255:0] key_i;
  logic         key_update_i, key_len_update_i;
  logic [127:0] s_axis_tdata_i;
  logic         s_axis_tvalid_i, s_axis_tready_o;
  logic [7:0]   m_axis_tdata_o;
  logic         m_axis_tvalid_o, m_axis_tlast_o, m_axis_tkeep_o, m_axis_tstrb_o;
  logic         m_axis_tid_o, m_axis_tdest_o, m_axis_tuser_o, m_axis_tready_i;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [255:0] KEY_STD = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_B   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PT_STD  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT128   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;

  aes_cipher dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .key_len_i(key_len_i), .key_i(key_i),
    .key_update_i(key_update_i), .key_len_update_i(key_len_update_i),
    .s_axis_tdata_i(s_axis_tdata_i), .s_axis_tvalid_i(s_axis_tvalid_i),
    .s_axis_tready_o(s_axis_tready_o), .m_axis_tdata_o(m_axis_tdata_o),
    .m_axis_tvalid_o(m_axis_tvalid_o), .m_axis_tlast_o(m_axis_tlast_o),
    .m_axis_tkeep_o(m_axis_tkeep_o), .m_axis_tstrb_o(m_axis_tstrb_o),
    .m_axis_tid_o(m_axis_tid_o), .m_axis_tdest_o(m_axis_tdest_o),
    .m_axis_tuser_o(m_axis_tuser_o), .m_axis_tready_i(m_axis_tready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Strobe key and/or length, then count cycles until the input side is ready again.
  task automatic load_key(input logic [255:0] k, input logic [1:0] len, input bit uk,
                          input bit ul, output int cycles);
    key_i = k;
    key_len_i = len;
    key_update_i = uk;
    key_len_update_i = ul;
    tick();
    key_update_i = 1'b0;
    key_len_update_i = 1'b0;
    cycles = 0;
    while (!s_axis_tready_o && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  // Push one block, then collect 16 bytes; lat is cycles from accept edge to first tvalid.
  task automatic do_block(input logic [127:0] pt, input bit bp, output logic [127:0] got,
                          output int lat, output int last_err, output int stall_err);
    bit ok = 0;
    int n = 0;
    int cyc = 0;
    bit stalled = 0;
    logic [7:0] prev = '0;
    got = 'x;
    lat = -1;
    last_err = 0;
    stall_err = 0;
    s_axis_tdata_i = pt;
    s_axis_tvalid_i = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (s_axis_tready_o) ok = 1;
      tick();
    end
    s_axis_tvalid_i = 1'b0;
    if (!ok) return;
    while (n < 16 && cyc < 400) begin
      m_axis_tready_i = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (m_axis_tvalid_o) begin
        if (lat < 0) lat = cyc;
        if (stalled && m_axis_tdata_o !== prev) stall_err++;
        if (m_axis_tlast_o !== (n == 15)) last_err++;
        if (m_axis_tready_i) begin
          got = {got[119:0], m_axis_tdata_o};
          n++;
          stalled = 0;
        end else begin
          stalled = 1;
          prev = m_axis_tdata_o;
        end
      end
      tick();
      cyc++;
    end
    m_axis_tready_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) tick();
    vectors++;
    if (s_axis_tready_o !== 1'b0) begin miscompares++; $display("FAIL reset tready: got %b expected 0", s_axis_tready_o); end
    vectors++;
    if (m_axis_tvalid_o !== 1'b0) begin miscompares++; $display("FAIL reset tvalid: got %b expected 0", m_axis_tvalid_o); end
    vectors++;
    if (m_axis_tlast_o !== 1'b0) begin miscompares++; $display("FAIL reset tlast: got %b expected 0", m_axis_tlast_o); end
    vectors++;
    if (m_axis_tdata_o !== 8'h00) begin miscompares++; $display("FAIL reset tdata: got %h expected 00", m_axis_tdata_o); end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_nokey();
    bit seen_rdy = 0;
    bit seen_val = 0;
    s_axis_tdata_i = PT_STD;
    s_axis_tvalid_i = 1'b1;
    repeat (60) begin
      if (s_axis_tready_o) seen_rdy = 1;
      if (m_axis_tvalid_o) seen_val = 1;
      tick();
    end
    s_axis_tvalid_i = 1'b0;
    vectors++;
    if (seen_rdy !== 1'b0) begin miscompares++; $display("FAIL nokey tready: got %b expected 0", seen_rdy); end
    vectors++;
    if (seen_val !== 1'b0) begin miscompares++; $display("FAIL nokey tvalid: got %b expected 0", seen_val); end
  endtask

  // New key, then the same block again on the cached schedule.
  task automatic test_keylen(input string name, input logic [255:0] k, input logic [1:0] len,
                             input bit uk, input int exp_cyc, input int nr, input logic [127:0] exp);
    int cyc, lat, le, se;
    logic [127:0] got;
    load_key(k, len, uk, 1'b1, cyc);
    vectors++;
    if (cyc !== exp_cyc) begin miscompares++; $display("FAIL %s keyexp cycles: got %0d expected %0d", name, cyc, exp_cyc); end
    do_block(PT_STD, 1'b0, got, lat, le, se);
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL %s new-key data: got %h expected %h", name, got, exp); end
    vectors++;
    if (lat !== nr) begin miscompares++; $display("FAIL %s latency: got %0d expected %0d", name, lat, nr); end
    vectors++;
    if (le !== 0) begin miscompares++; $display("FAIL %s tlast: got %0d errors expected 0", name, le); end
    vectors++;
    if (m_axis_tvalid_o !== 1'b0) begin miscompares++; $display("FAIL %s tvalid after byte 15: got %b expected 0", name, m_axis_tvalid_o); end
    vectors++;
    if (s_axis_tready_o !== 1'b1) begin miscompares++; $display("FAIL %s cached ready: got %b expected 1", name, s_axis_tready_o); end
    do_block(PT_STD, 1'b0, got, lat, le, se);
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL %s cached data: got %h expected %h", name, got, exp); end
    vectors++;
    if (lat !== nr) begin miscompares++; $display("FAIL %s cached latency: got %0d expected %0d", name, lat, nr); end
  endtask

  task automatic test_backpressure();
    int lat, le, se;
    logic [127:0] got;
    do_block(PT_STD, 1'b1, got, lat, le, se);
    vectors++;
    if (got !== CT256) begin miscompares++; $display("FAIL backpressure data: got %h expected %h", got, CT256); end
    vectors++;
    if (se !== 0) begin miscompares++; $display("FAIL backpressure stability: got %0d changes expected 0", se); end
    vectors++;
    if (le !== 0) begin miscompares++; $display("FAIL backpressure tlast: got %0d errors expected 0", le); end
  endtask

  task automatic wait_accept();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (s_axis_tvalid_i && s_axis_tready_o) break;
    end
    tick();
  endtask

  task automatic test_enable_stall();
    int lat, le, se;
    logic [127:0] got;
    fork
      do_block(PT_STD, 1'b0, got, lat, le, se);
      begin
        wait_accept();
        repeat (3) tick();
        en_i = 1'b0;
        repeat (5) tick();
        en_i = 1'b1;
      end
    join
    vectors++;
    if (got !== CT256) begin miscompares++; $display("FAIL enable stall data: got %h expected %h", got, CT256); end
    vectors++;
    if (lat !== 19) begin miscompares++; $display("FAIL enable stall latency: got %0d expected 19", lat); end
  endtask

  task automatic test_key_update_in_output();
    int lat, le, se, cyc;
    logic [127:0] got;
    fork
      do_block(PT_STD, 1'b0, got, lat, le, se);
      begin
        wait_accept();
        repeat (12) tick();
        key_i = KEY_B;
        key_len_i = 2'b00;
        key_update_i = 1'b1;
        key_len_update_i = 1'b1;
        tick();
        key_update_i = 1'b0;
        key_len_update_i = 1'b0;
      end
    join
    vectors++;
    if (got !== CT256) begin miscompares++; $display("FAIL key update old block: got %h expected %h", got, CT256); end
    vectors++;
    if (s_axis_tready_o !== 1'b0) begin miscompares++; $display("FAIL key update keyexp tready: got %b expected 0", s_axis_tready_o); end
    cyc = 0;
    while (!s_axis_tready_o && cyc < 200) begin
      tick();
      cyc++;
    end
    do_block(PT_B, 1'b0, got, lat, le, se);
    vectors++;
    if (got !== CT_B) begin miscompares++; $display("FAIL key update new block: got %h expected %h", got, CT_B); end
  endtask

  task automatic test_reset_mid_round();
    int cyc, lat, le, se;
    logic [127:0] got;
    s_axis_tdata_i = PT_B;
    s_axis_tvalid_i = 1'b1;
    cyc = 0;
    while (!s_axis_tready_o && cyc < 200) begin
      tick();
      cyc++;
    end
    tick();
    s_axis_tvalid_i = 1'b0;
    repeat (3) tick();
    rst_i = 1'b1;
    #1;
    vectors++;
    if (m_axis_tvalid_o !== 1'b0) begin miscompares++; $display("FAIL mid-round reset tvalid: got %b expected 0", m_axis_tvalid_o); end
    vectors++;
    if (s_axis_tready_o !== 1'b0) begin miscompares++; $display("FAIL mid-round reset tready: got %b expected 0", s_axis_tready_o); end
    repeat (2) tick();
    rst_i = 1'b0;
    tick();
    test_nokey();
    load_key(KEY_STD, 2'b00, 1'b1, 1'b1, cyc);
    vectors++;
    if (cyc !== 41) begin miscompares++; $display("FAIL post-reset keyexp cycles: got %0d expected 41", cyc); end
    do_block(PT_STD, 1'b0, got, lat, le, se);
    vectors++;
    if (got !== CT128) begin miscompares++; $display("FAIL post-reset data: got %h expected %h", got, CT128); end
  endtask

  initial begin
    rst_i = 1'b1;
    en_i = 1'b1;
    key_len_i = 2'b00;
    key_i = '0;
    key_update_i = 1'b0;
    key_len_update_i = 1'b0;
    s_axis_tdata_i = '0;
    s_axis_tvalid_i = 1'b0;
    m_axis_tready_i = 1'b1;
    test_reset();
    test_nokey();
    test_keylen("aes128", KEY_STD, 2'b00, 1'b1, 41, 10, CT128);
    test_keylen("aes192", KEY_STD, 2'b01, 1'b0, 47, 12, CT192);
    test_keylen("aes256", KEY_STD, 2'b10, 1'b0, 53, 14, CT256);
    test_backpressure();
    test_enable_stall();
    test_key_update_in_output();
    test_reset_mid_round();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
